// File: rtl/ex_stage_pipe.sv
// Execute stage: operand select, single-cycle ALU, branch compare and target,
// plus an iterative radix-2 multiply / restoring divide unit. There is one
// registered output slot, with valid/ready handshakes on both sides.
module ex_stage_pipe #(
  parameter int WIDTH     = 32,
  parameter int RD_W      = 5,
  parameter int MULDIV_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_op,
  input  logic [2:0]       br_op,
  input  logic             sel_pc,
  input  logic             sel_imm,
  input  logic [WIDTH-1:0] src0,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] br_offs,
  input  logic [RD_W-1:0]  rd_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             br_taken,
  output logic [WIDTH-1:0] br_target,
  output logic [RD_W-1:0]  rd_out,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state, state_n;

  logic [WIDTH-1:0]   op_a, op_b, alu_res, tgt;
  logic [SHW-1:0]     shamt;
  logic               br_c, xfer, is_md, is_mul, md_signed, fix_load;
  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;

  // muldiv datapath: acc holds {hi,lo} = product or {remainder,quotient}
  logic [2*WIDTH-1:0] acc, acc_mul, acc_div, prod_fix;
  logic [WIDTH-1:0]   opb, q_fix, r_fix, md_res;
  logic [WIDTH:0]     mul_sum, div_rs, div_diff;
  logic               div_ge;
  logic [SHW-1:0]     cnt;
  logic [2:0]         md_op;
  logic               neg_q, neg_r, dz;
  logic [RD_W-1:0]    rd_q;
  logic [WIDTH-1:0]   tgt_q;

  assign op_a  = sel_pc  ? pc  : src1;
  assign op_b  = sel_imm ? imm : src2;
  assign shamt = op_b[SHW-1:0];
  assign tgt   = op_a + br_offs;

  assign is_md     = (MULDIV_EN != 0) && (alu_op >= 5'd16) && (alu_op <= 5'd22);
  assign is_mul    = (alu_op <= 5'd18);
  assign md_signed = (alu_op == 5'd17) || (alu_op == 5'd19) || (alu_op == 5'd20);

  // The reset pin gates in_ready so the stage advertises nothing while held in reset
  assign in_ready = rst && (state == IDLE) && !flush && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // Muldiv operands are stored as magnitudes; the sign is reapplied in FIX
  assign sa    = md_signed & op_a[WIDTH-1];
  assign sb    = md_signed & op_b[WIDTH-1];
  assign mag_a = sa ? -op_a : op_a;
  assign mag_b = sb ? -op_b : op_b;

  // single-cycle ALU
  always_comb begin
    alu_res = '0;
    case (alu_op)
      5'd0:  alu_res = op_a + op_b;
      5'd1:  alu_res = op_a - op_b;
      5'd2:  alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      5'd3:  alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
      5'd4:  alu_res = op_a & op_b;
      5'd5:  alu_res = op_a | op_b;
      5'd6:  alu_res = ~(op_a | op_b);
      5'd7:  alu_res = op_a ^ op_b;
      5'd8:  alu_res = op_a << shamt;
      5'd9:  alu_res = op_a >> shamt;
      5'd10: alu_res = $unsigned($signed(op_a) >>> shamt);
      5'd11: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  // branch condition on src0 vs src1
  always_comb begin
    br_c = 1'b0;
    case (br_op)
      3'd1: br_c = (src0 == src1);
      3'd2: br_c = (src0 != src1);
      3'd3: br_c = ($signed(src0) <  $signed(src1));
      3'd4: br_c = ($signed(src0) >= $signed(src1));
      3'd5: br_c = (src0 <  src1);
      3'd6: br_c = (src0 >= src1);
      3'd7: br_c = 1'b1;
      default: br_c = 1'b0;
    endcase
  end

  // one shift-add step and one restoring-divide step, plus the FIX sign correction
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    acc_mul  = {mul_sum, acc[WIDTH-1:1]};
    div_rs   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge   = (div_rs >= {1'b0, opb});
    div_diff = div_rs - {1'b0, opb};
    acc_div  = {(div_ge ? div_diff[WIDTH-1:0] : div_rs[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    prod_fix = neg_q ? -acc : acc;
    q_fix    = dz ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    case (md_op)
      3'd0:       md_res = prod_fix[WIDTH-1:0];
      3'd1, 3'd2: md_res = prod_fix[2*WIDTH-1:WIDTH];
      3'd3, 3'd5: md_res = q_fix;
      3'd4, 3'd6: md_res = r_fix;
      default:    md_res = '0;
    endcase
  end

  // muldiv FSM next state; flush overrides everything
  always_comb begin
    state_n  = state;
    fix_load = 1'b0;
    case (state)
      IDLE:     if (xfer && is_md) state_n = is_mul ? MUL : DIV;
      MUL, DIV: if (cnt == '0) state_n = FIX;
      FIX: if (!out_valid || out_ready) begin
        state_n  = IDLE;
        fix_load = 1'b1;
      end
      default:  state_n = IDLE;
    endcase
    if (flush) begin
      state_n  = IDLE;
      fix_load = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // muldiv operand capture and iteration
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0; opb <= '0; cnt <= '0; md_op <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; dz <= 1'b0; rd_q <= '0; tgt_q <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (xfer && is_md) begin
      acc   <= {{WIDTH{1'b0}}, mag_a};
      opb   <= mag_b;
      cnt   <= SHW'(WIDTH-1);
      md_op <= alu_op[2:0];
      neg_q <= sa ^ sb;
      neg_r <= sa;
      dz    <= (op_b == '0);
      rd_q  <= rd_in;
      tgt_q <= tgt;
    end else if (state == MUL || state == DIV) begin
      acc <= (state == MUL) ? acc_mul : acc_div;
      cnt <= cnt - 1'b1;
    end
  end

  // output slot: flush > single-cycle load > muldiv completion > drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0; result <= '0; br_taken <= 1'b0; br_target <= '0; rd_out <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer && !is_md) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      br_taken  <= br_c;
      br_target <= tgt;
      rd_out    <= rd_in;
    end else if (fix_load) begin
      out_valid <= 1'b1;
      result    <= md_res;
      br_taken  <= 1'b0;
      br_target <= tgt_q;
      rd_out    <= rd_q;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe at WIDTH=32 with hand-computed expectations.
module tb_ex_stage_pipe;
  logic        clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, br_taken, busy, sel_pc = 1'b0, sel_imm = 1'b0;
  logic [4:0]  alu_op = '0, rd_in = '0, rd_out;
  logic [2:0]  br_op = '0;
  logic [31:0] src0 = '0, src1 = '0, src2 = '0, imm = '0, pc = '0, br_offs = '0;
  logic [31:0] result, br_target;
  int n_chk = 0, n_err = 0;

  ex_stage_pipe #(.WIDTH(32), .RD_W(5), .MULDIV_EN(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .br_op(br_op), .sel_pc(sel_pc), .sel_imm(sel_imm),
    .src0(src0), .src1(src1), .src2(src2), .imm(imm), .pc(pc), .br_offs(br_offs),
    .rd_in(rd_in), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .br_taken(br_taken), .br_target(br_target), .rd_out(rd_out), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [2:0] br, input logic spc, input logic simm,
                       input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] im, input logic [31:0] p, input logic [31:0] offs,
                       input logic [4:0] rd);
    alu_op = op; br_op = br; sel_pc = spc; sel_imm = simm;
    src0 = s0; src1 = s1; src2 = s2; imm = im; pc = p; br_offs = offs; rd_in = rd;
    in_valid = 1'b1;
  endtask

  task automatic run_md(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int cyc;
    drive(op, 3'd0, 1'b0, 1'b0, 32'd0, a, b, 32'd0, 32'd0, 32'd0, 5'd3);
    step();
    in_valid = 1'b0;
    chk({tag, " busy"}, busy, 1);
    chk({tag, " in_ready"}, in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      step();
      cyc++;
    end
    chk({tag, " latency"}, cyc, 33);
    chk({tag, " result"}, result, exp);
    chk({tag, " br_taken"}, br_taken, 0);
  endtask

  initial begin
    int seen;
    // reset state
    repeat (3) step();
    chk("rst out_valid", out_valid, 0);
    chk("rst result", result, 0);
    chk("rst br", {br_taken, br_target, rd_out}, 0);
    chk("rst busy", busy, 0);
    chk("rst in_ready", in_ready, 0);
    rst = 1'b1; #1;
    chk("post-rst in_ready", in_ready, 1);
    out_ready = 1'b1;

    // back-to-back ADD then SRA
    drive(5'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd7, 32'd5, 32'd0, 32'd0, 32'd0, 5'd1);
    step();
    chk("add result", result, 32'd12);
    chk("add vld/rd", {out_valid, rd_out}, {1'b1, 5'd1});
    drive(5'd10, 3'd0, 1'b0, 1'b1, 32'd0, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 32'd0, 5'd2);
    chk("sra in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("sra result", {out_valid, result}, {1'b1, 32'hF800_0000});
    step();
    chk("drain", out_valid, 0);

    // branches
    drive(5'd0, 3'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'h1C00_0000, 32'h40, 5'd4);
    step();
    chk("blt taken", br_taken, 1);
    chk("blt target", br_target, 32'h1C00_0040);
    br_op = 3'd5;
    step();
    chk("bltu taken", br_taken, 0);
    chk("bltu target", br_target, 32'h1C00_0040);
    drive(5'd0, 3'd4, 1'b0, 1'b0, 32'd5, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 5'd4);
    step();
    chk("bge eq", br_taken, 1);
    drive(5'd0, 3'd7, 1'b0, 1'b0, 32'd0, 32'h100, 32'd0, 32'd0, 32'h5000, 32'h10, 5'd4);
    step();
    in_valid = 1'b0;
    chk("jmp", {br_taken, br_target}, {1'b1, 32'h110});
    step();

    // multiply / divide
    run_md("mulh",  5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    run_md("mulhu", 5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_md("mul",   5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
    run_md("div",   5'd19, -32'sd7, 32'd2, -32'sd3);
    run_md("mod",   5'd20, -32'sd7, 32'd2, -32'sd1);
    run_md("mod+-", 5'd20, 32'd7, -32'sd2, 32'd1);
    run_md("divu0", 5'd21, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_md("modu0", 5'd22, 32'd5, 32'd0, 32'd5);
    run_md("divmin", 5'd19, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    step();

    // backpressure: result held for 5 cycles, then drains one beat
    out_ready = 1'b0;
    drive(5'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd1, 32'd2, 32'd0, 32'd0, 32'd0, 5'd6);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold", {out_valid, in_ready, result}, {1'b1, 1'b0, 32'd3});
      step();
    end
    out_ready = 1'b1; #1;
    chk("release in_ready", in_ready, 1);
    step();
    chk("drained", out_valid, 0);

    // flush kills a stalled output slot
    out_ready = 1'b0;
    drive(5'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 5'd6);
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush slot", out_valid, 0);
    out_ready = 1'b1;

    // flush in cycle 10 of a DIV, with an input offered that same cycle
    drive(5'd19, 3'd0, 1'b0, 1'b0, 32'd0, 32'd100, 32'd3, 32'd0, 32'd0, 32'd0, 5'd7);
    step();
    in_valid = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    drive(5'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd9, 32'd9, 32'd0, 32'd0, 32'd0, 5'd8);
    chk("flush in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush busy/vld", {busy, out_valid}, 0);
    seen = 0;
    repeat (40) begin
      step();
      if (out_valid) seen++;
    end
    chk("flush no result", seen, 0);
    drive(5'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd4, 32'd4, 32'd0, 32'd0, 32'd0, 5'd9);
    chk("post-flush in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("post-flush add", {out_valid, result, rd_out}, {1'b1, 32'd8, 5'd9});
    step();

    // reset in the middle of a multiply
    drive(5'd16, 3'd0, 1'b0, 1'b0, 32'd0, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 5'd1);
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rst = 1'b0; #1;
    chk("mid rst", {busy, out_valid, in_ready}, 0);
    step();
    rst = 1'b1;
    seen = 0;
    repeat (40) begin
      step();
      if (out_valid) seen++;
    end
    chk("mid rst no result", seen, 0);
    run_md("mul after rst", 5'd16, 32'd3, 32'd4, 32'd12);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
